// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the micro-CPU sequencer: opcode groups,
// special sub-codes, ALU operation codes and the FSM state type.
package secuenciador_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } estado_t;

    // opcode[5:2] groups; 0100..1011 is the register-operand ALU range
    localparam logic [3:0] OPC_I0   = 4'b0000;
    localparam logic [3:0] OPC_I1   = 4'b0001;
    localparam logic [3:0] OPC_CMPI = 4'b0010;
    localparam logic [3:0] OPC_I3   = 4'b0011;
    localparam logic [3:0] OPC_J    = 4'b1100;
    localparam logic [3:0] OPC_JZ   = 4'b1101;
    localparam logic [3:0] OPC_JNZ  = 4'b1110;
    localparam logic [3:0] OPC_ESP  = 4'b1111;

    localparam logic [1:0] SUB_CALL = 2'b00;
    localparam logic [1:0] SUB_RET  = 2'b01;
    localparam logic [1:0] SUB_NOP  = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    localparam logic [2:0] ALU_I0  = 3'b000;
    localparam logic [2:0] ALU_I1  = 3'b010;
    localparam logic [2:0] ALU_CMP = 3'b011;
    localparam logic [2:0] ALU_I3  = 3'b110;

    // Register-operand ALU op is the group code offset by 4
    function automatic logic [2:0] op_registro(input logic [3:0] grupo);
        logic [3:0] t;
        t = grupo - 4'd4;
        return t[2:0];
    endfunction

endpackage

// File: rtl/secuenciador_cpu_if.sv
// Instruction-fetch handshake between the sequencer (master) and the
// instruction memory / instruction register side (slave).
interface secuenciador_cpu_if;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_load;
    logic [5:0] opcode;

    modport master (output imem_req, output ir_load, input imem_ack, input opcode);
    modport slave  (input imem_req, input ir_load, output imem_ack, output opcode);
endinterface

// File: rtl/pila_retorno.sv
// Return-address stack for CALL/RET: PROF_PILA entries, pointer saturates
// at 0 and PROF_PILA (push when full and pop when empty are ignored).
module pila_retorno #(
    parameter int ANCHO_PC  = 10,
    parameter int PROF_PILA = 4
) (
    input  logic                reloj,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [ANCHO_PC-1:0] din,
    output logic [ANCHO_PC-1:0] top,
    output logic                llena,
    output logic                vacia
);
    localparam int AW = $clog2(PROF_PILA);
    localparam logic [AW:0] SP_MAX = (AW+1)'(PROF_PILA);
    localparam logic [AW:0] SP_UNO = {{AW{1'b0}}, 1'b1};

    logic [ANCHO_PC-1:0] mem_q [PROF_PILA];
    logic [ANCHO_PC-1:0] mem_d [PROF_PILA];
    logic [AW:0]         sp_q, sp_d, sp_m1_s;

    assign llena   = (sp_q == SP_MAX);
    assign vacia   = (sp_q == '0);
    assign sp_m1_s = sp_q - SP_UNO;
    assign top     = mem_q[sp_m1_s[AW-1:0]];

    // Next stack contents and pointer
    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push && !llena) begin
            mem_d[sp_q[AW-1:0]] = din;
            sp_d                = sp_q + SP_UNO;
        end else if (pop && !vacia) begin
            sp_d = sp_m1_s;
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack state registers
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/secuenciador_cpu.sv
// Multicycle FETCH/DECODE/EXEC sequencer for the micro-CPU datapath with
// zero-conditional jumps, CALL/RET through a return stack, and HALT.
module secuenciador_cpu
    import secuenciador_pkg::*;
#(
    parameter int ANCHO_PC  = 10,
    parameter int PROF_PILA = 4
) (
    input  logic                reloj,
    input  logic                reset,
    secuenciador_cpu_if.master  imem,
    input  logic                zero,
    input  logic [ANCHO_PC-1:0] pc_mas1,
    output logic                pc_load,
    output logic                s_inc,
    output logic                s_ret,
    output logic [ANCHO_PC-1:0] ret_addr,
    output logic                s_inm,
    output logic [2:0]          Op,
    output logic                we3,
    output logic                wez,
    output logic                halted,
    output logic                pila_err
);
    estado_t    estado_q, estado_d;
    logic       imem_req_q, imem_req_d;
    logic       pc_load_q, pc_load_d, s_inc_q, s_inc_d, s_ret_q, s_ret_d;
    logic       s_inm_q, s_inm_d, we3_q, we3_d, wez_q, wez_d;
    logic [2:0] op_q, op_d;
    logic       halted_q, halted_d, pila_err_q, pila_err_d;
    logic       push_q, push_d, pop_q, pop_d, fin_q, fin_d, err_q, err_d;
    logic       ir_load_s, llena_s, vacia_s;

    // A fetch only completes once our own request is visible to memory
    assign ir_load_s     = imem_req_q & imem.imem_ack;
    assign imem.ir_load  = ir_load_s;
    assign imem.imem_req = imem_req_q;

    pila_retorno #(.ANCHO_PC(ANCHO_PC), .PROF_PILA(PROF_PILA)) u_pila (
        .reloj (reloj),
        .reset (reset),
        .push  (push_q),
        .pop   (pop_q),
        .din   (pc_mas1),
        .top   (ret_addr),
        .llena (llena_s),
        .vacia (vacia_s)
    );

    // Next state; EXEC controls are decoded in DECODE so they are flop outputs in EXEC
    always_comb begin
        estado_d   = estado_q;
        imem_req_d = 1'b0;
        pc_load_d  = 1'b0;
        s_inc_d    = 1'b0;
        s_ret_d    = 1'b0;
        s_inm_d    = 1'b0;
        op_d       = 3'b000;
        we3_d      = 1'b0;
        wez_d      = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        fin_d      = 1'b0;
        err_d      = 1'b0;
        halted_d   = halted_q;
        pila_err_d = pila_err_q;
        case (estado_q)
            FETCH: begin
                if (ir_load_s) begin
                    estado_d = DECODE;
                end else begin
                    estado_d   = FETCH;
                    imem_req_d = 1'b1;
                end
            end
            DECODE: begin
                estado_d = EXEC;
                case (imem.opcode[5:2])
                    OPC_I0:   begin op_d = ALU_I0;  s_inm_d = 1'b1; we3_d = 1'b1; wez_d = 1'b1; pc_load_d = 1'b1; s_inc_d = 1'b1; end
                    OPC_I1:   begin op_d = ALU_I1;  s_inm_d = 1'b1; we3_d = 1'b1; wez_d = 1'b1; pc_load_d = 1'b1; s_inc_d = 1'b1; end
                    OPC_CMPI: begin op_d = ALU_CMP; s_inm_d = 1'b1; wez_d = 1'b1; pc_load_d = 1'b1; s_inc_d = 1'b1; end
                    OPC_I3:   begin op_d = ALU_I3;  s_inm_d = 1'b1; we3_d = 1'b1; wez_d = 1'b1; pc_load_d = 1'b1; s_inc_d = 1'b1; end
                    OPC_J:    begin pc_load_d = 1'b1; end
                    OPC_JZ:   begin pc_load_d = 1'b1; s_inc_d = ~zero; end
                    OPC_JNZ:  begin pc_load_d = 1'b1; s_inc_d = zero; end
                    OPC_ESP: begin
                        case (imem.opcode[1:0])
                            SUB_CALL: begin
                                if (llena_s) begin
                                    fin_d = 1'b1;
                                    err_d = 1'b1;
                                end else begin
                                    push_d    = 1'b1;
                                    pc_load_d = 1'b1;
                                end
                            end
                            SUB_RET: begin
                                if (vacia_s) begin
                                    fin_d = 1'b1;
                                    err_d = 1'b1;
                                end else begin
                                    pop_d     = 1'b1;
                                    pc_load_d = 1'b1;
                                    s_ret_d   = 1'b1;
                                end
                            end
                            SUB_NOP:  begin pc_load_d = 1'b1; s_inc_d = 1'b1; end
                            default:  begin fin_d = 1'b1; end
                        endcase
                    end
                    default: begin
                        op_d      = op_registro(imem.opcode[5:2]);
                        we3_d     = 1'b1;
                        wez_d     = 1'b1;
                        pc_load_d = 1'b1;
                        s_inc_d   = 1'b1;
                    end
                endcase
            end
            EXEC: begin
                if (fin_q) begin
                    estado_d   = HALT;
                    halted_d   = 1'b1;
                    pila_err_d = pila_err_q | err_q;
                end else begin
                    estado_d   = FETCH;
                    imem_req_d = 1'b1;
                end
            end
            HALT:    begin estado_d = HALT; end
            default: begin estado_d = FETCH; end
        endcase
    end

    // State and output registers
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado_q   <= FETCH;
            imem_req_q <= 1'b0;
            pc_load_q  <= 1'b0;
            s_inc_q    <= 1'b0;
            s_ret_q    <= 1'b0;
            s_inm_q    <= 1'b0;
            op_q       <= 3'b000;
            we3_q      <= 1'b0;
            wez_q      <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            fin_q      <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
            pila_err_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            imem_req_q <= imem_req_d;
            pc_load_q  <= pc_load_d;
            s_inc_q    <= s_inc_d;
            s_ret_q    <= s_ret_d;
            s_inm_q    <= s_inm_d;
            op_q       <= op_d;
            we3_q      <= we3_d;
            wez_q      <= wez_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            fin_q      <= fin_d;
            err_q      <= err_d;
            halted_q   <= halted_d;
            pila_err_q <= pila_err_d;
        end
    end

    assign pc_load  = pc_load_q;
    assign s_inc    = s_inc_q;
    assign s_ret    = s_ret_q;
    assign s_inm    = s_inm_q;
    assign Op       = op_q;
    assign we3      = we3_q;
    assign wez      = wez_q;
    assign halted   = halted_q;
    assign pila_err = pila_err_q;
endmodule

// File: tb/tb_secuenciador_cpu.sv
// Scoreboard bench for secuenciador_cpu: a driver feeds instructions and a
// behavioural model queues the expected EXEC response; a monitor compares.
module tb_secuenciador_cpu;
    localparam int ANCHO = 10;
    localparam int PROF  = 4;

    logic             reloj = 1'b0;
    logic             reset = 1'b0;
    logic             zero  = 1'b0;
    logic [ANCHO-1:0] pc_mas1 = '0;
    logic             pc_load, s_inc, s_ret, s_inm, we3, wez, halted, pila_err;
    logic [2:0]       Op;
    logic [ANCHO-1:0] ret_addr;

    secuenciador_cpu_if imem ();

    secuenciador_cpu #(.ANCHO_PC(ANCHO), .PROF_PILA(PROF)) dut (
        .reloj    (reloj),
        .reset    (reset),
        .imem     (imem.master),
        .zero     (zero),
        .pc_mas1  (pc_mas1),
        .pc_load  (pc_load),
        .s_inc    (s_inc),
        .s_ret    (s_ret),
        .ret_addr (ret_addr),
        .s_inm    (s_inm),
        .Op       (Op),
        .we3      (we3),
        .wez      (wez),
        .halted   (halted),
        .pila_err (pila_err)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic             pc_load, s_inc, s_ret, s_inm, we3, wez;
        logic [2:0]       op;
        logic             chk_ret;
        logic [ANCHO-1:0] ret;
        logic             fin, err;
    } exp_t;

    exp_t             expq[$];
    logic [ANCHO-1:0] pila[$];
    int               n_tests = 0, n_fail = 0, n_irload = 0, n_issued = 0;
    logic             mon_en = 1'b0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, act, req);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, imem.imem_req, imem.ir_load, pc_load, s_inc, s_ret, s_inm, Op,
                we3, wez, halted, pila_err, ret_addr};
    endfunction

    // Reference model: what EXEC must show for one instruction
    task automatic modelo(input logic [5:0] opc, input logic z, input logic [ANCHO-1:0] pc, output exp_t e);
        int g;
        g = int'(opc[5:2]);
        e = '{default: '0};
        if (g <= 3) begin
            e.s_inm = 1'b1; e.wez = 1'b1; e.we3 = (g != 2); e.pc_load = 1'b1; e.s_inc = 1'b1;
            case (g)
                0: e.op = 3'd0;
                1: e.op = 3'd2;
                2: e.op = 3'd3;
                default: e.op = 3'd6;
            endcase
        end else if (g <= 11) begin
            e.op = 3'(g - 4); e.we3 = 1'b1; e.wez = 1'b1; e.pc_load = 1'b1; e.s_inc = 1'b1;
        end else if (g == 12) begin
            e.pc_load = 1'b1;
        end else if (g == 13) begin
            e.pc_load = 1'b1; e.s_inc = !z;
        end else if (g == 14) begin
            e.pc_load = 1'b1; e.s_inc = z;
        end else begin
            case (opc[1:0])
                2'b00: if (pila.size() >= PROF) begin e.fin = 1'b1; e.err = 1'b1; end
                       else begin pila.push_back(pc); e.pc_load = 1'b1; end
                2'b01: if (pila.size() == 0) begin e.fin = 1'b1; e.err = 1'b1; end
                       else begin e.ret = pila.pop_back(); e.chk_ret = 1'b1; e.pc_load = 1'b1; e.s_ret = 1'b1; end
                2'b10: begin e.pc_load = 1'b1; e.s_inc = 1'b1; end
                default: e.fin = 1'b1;
            endcase
        end
    endtask

    task automatic do_reset();
        @(posedge reloj); #1 reset = 1'b0;
        pila.delete();
        repeat (2) @(posedge reloj);
        #1;
        chk("reset_clears", all_outs(), 32'd0);
        reset = 1'b1;
    endtask

    // Driver: one instruction fetch with a given ack delay, then wait out DECODE/EXEC
    task automatic issue(input logic [5:0] opc, input logic z, input logic [ANCHO-1:0] pc, input int d);
        exp_t e;
        int   t;
        logic bad;
        t = 0;
        @(negedge reloj);
        while (imem.imem_req !== 1'b1 && t < 20) begin @(negedge reloj); t++; end
        if (imem.imem_req !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL imem_req_timeout: got %b, expected 1", imem.imem_req);
            return;
        end
        repeat (d) @(posedge reloj);
        @(posedge reloj); #1;
        imem.opcode = opc; zero = z; pc_mas1 = pc; imem.imem_ack = 1'b1;
        modelo(opc, z, pc, e);
        expq.push_back(e);
        n_issued++;
        @(posedge reloj); #1 imem.imem_ack = 1'b0;
        @(posedge reloj); @(posedge reloj); #1;
        if (e.fin) begin
            bad = 1'b0;
            repeat (12) begin
                @(negedge reloj);
                if (imem.imem_req !== 1'b0 || halted !== 1'b1) bad = 1'b1;
            end
            chk("halt_holds", 32'(bad), 32'd0);
            do_reset();
        end
    endtask

    // Monitor: EXEC is two cycles after the ir_load pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge reloj);
            if (mon_en && imem.ir_load === 1'b1) begin
                n_irload++;
                @(negedge reloj);
                @(negedge reloj);
                if (expq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard: got an instruction, expected none queued");
                end else begin
                    e = expq.pop_front();
                    chk("exec_ctrl", {23'd0, pc_load, s_inc, s_ret, s_inm, Op, we3, wez},
                        {23'd0, e.pc_load, e.s_inc, e.s_ret, e.s_inm, e.op, e.we3, e.wez});
                    if (e.chk_ret) chk("ret_addr", 32'(ret_addr), 32'(e.ret));
                    @(negedge reloj);
                    chk("halted", 32'(halted), 32'(e.fin));
                    chk("pila_err", 32'(pila_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : estimulo
        int t;
        imem.imem_ack = 1'b0;
        imem.opcode   = 6'd0;
        repeat (3) @(posedge reloj);
        #1 chk("reset_state", all_outs(), 32'd0);
        reset = 1'b1;

        // Asynchronous reset in the middle of an EXEC that writes the register file
        t = 0;
        @(negedge reloj);
        while (imem.imem_req !== 1'b1 && t < 20) begin @(negedge reloj); t++; end
        @(posedge reloj); #1 imem.imem_ack = 1'b1; imem.opcode = 6'b010100;
        @(posedge reloj); #1 imem.imem_ack = 1'b0;
        @(posedge reloj); #1 chk("t1_exec_we3", 32'(we3), 32'd1);
        #2 reset = 1'b0;
        #1 chk("t1_async_reset", all_outs(), 32'd0);
        @(posedge reloj); #1 reset = 1'b1;
        @(posedge reloj); #1 chk("t1_req_first_edge", 32'(imem.imem_req), 32'd1);

        mon_en = 1'b1;
        issue(6'b010100, 1'b0, 10'h003, 3);
        issue(6'b110100, 1'b1, 10'h010, 0);
        issue(6'b110100, 1'b0, 10'h011, 1);
        issue(6'b111000, 1'b0, 10'h012, 0);
        issue(6'b111000, 1'b1, 10'h013, 2);
        issue(6'b111100, 1'b0, 10'h005, 0);
        issue(6'b111101, 1'b0, 10'h006, 1);
        issue(6'b111101, 1'b0, 10'h007, 0);
        for (int i = 0; i < 5; i++) issue(6'b111100, 1'b0, 10'(i + 32), i % 2);
        issue(6'b111111, 1'b0, 10'h020, 0);
        for (int i = 0; i < 90; i++)
            issue(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 1023)), $urandom_range(0, 3));

        t = 0;
        while (expq.size() != 0 && t < 50) begin @(negedge reloj); t++; end
        repeat (4) @(negedge reloj);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        chk("ir_load_count", 32'(n_irload), 32'(n_issued));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
